// File: rtl/vga_timing_controller_if.sv
// Pixel-side and pin-side signal bundle of the VGA timing controller.
// master: the timing controller; slave: the consumer side (image source and pins).
interface vga_timing_controller_if #(
    parameter int COLOR_DEPTH = 4
);
    logic [2:0]             color_in;
    logic [11:0]            x;
    logic [11:0]            y;
    logic                   pixel_active;
    logic                   frame_start;
    logic                   hsync;
    logic                   vsync;
    logic [COLOR_DEPTH-1:0] vga_r;
    logic [COLOR_DEPTH-1:0] vga_g;
    logic [COLOR_DEPTH-1:0] vga_b;
    logic                   vga_blank_n;

    modport master (
        input  color_in,
        output x, y, pixel_active, frame_start,
        output hsync, vsync, vga_r, vga_g, vga_b, vga_blank_n
    );

    modport slave (
        output color_in,
        input  x, y, pixel_active, frame_start,
        input  hsync, vsync, vga_r, vga_g, vga_b, vga_blank_n
    );
endinterface

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA timing generator. Stage 1 is combinational from the
// horizontal/vertical counters and hands x/y to the image source; stage 2
// registers colour and syncs together so each pixel leaves aligned with
// its own sync state.
module vga_timing_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int COLOR_DEPTH = 4
) (
    input  logic                      CLOCK_25,
    input  logic                      reset,
    vga_timing_controller_if.master   bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;

    logic h_in_active;
    logic v_in_active;
    logic active;
    logic hsync_raw;
    logic vsync_raw;

    logic                   hsync_q;
    logic                   vsync_q;
    logic                   blank_n_q;
    logic [COLOR_DEPTH-1:0] r_q;
    logic [COLOR_DEPTH-1:0] g_q;
    logic [COLOR_DEPTH-1:0] b_q;

    // Raster counters: h wraps every line, v advances only on the h wrap.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 12'd1;
            end
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    assign h_in_active = (h_cnt < H_ACT);
    assign v_in_active = (v_cnt < V_ACT);
    assign active      = h_in_active && v_in_active;

    // Sync pulses are active-low inside their window of the blanking region.
    assign hsync_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vsync_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

    // Coordinates are 1-based so 0 can mean "outside the visible area".
    assign bus.x            = h_in_active ? (h_cnt + 12'd1) : 12'd0;
    assign bus.y            = v_in_active ? (v_cnt + 12'd1) : 12'd0;
    assign bus.pixel_active = active;
    assign bus.frame_start  = (h_cnt == 12'd0) && (v_cnt == 12'd0) && !reset;

    // Output stage: colour is blanked outside the visible area, syncs share the same delay.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            hsync_q   <= hsync_raw;
            vsync_q   <= vsync_raw;
            blank_n_q <= active;
            r_q       <= {COLOR_DEPTH{active & bus.color_in[2]}};
            g_q       <= {COLOR_DEPTH{active & bus.color_in[1]}};
            b_q       <= {COLOR_DEPTH{active & bus.color_in[0]}};
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_r       = r_q;
    assign bus.vga_g       = g_q;
    assign bus.vga_b       = b_q;
endmodule
